// File: rtl/axis_ofmaps_unload.sv
// MAC result vector FIFO + serializer onto a 32-bit AXI-Stream master, TLAST per frame.
// Optional sticky overflow flag when AXIS_OFMAPS_UNLOAD_OVF_EN is defined.

module axis_ofmaps_unload_slot #(
    parameter int MAC_NUM = 256,
    parameter int VAL_W   = 5,
    parameter int VPB     = 6,
    parameter int K       = 0,
    parameter int BW      = 6
) (
    input  logic [MAC_NUM-1:0][VAL_W-1:0] vec,
    input  logic [BW-1:0]                 beat,
    input  logic [11:0]                   size,
    output logic [VAL_W-1:0]              val
);
    localparam int LANE_W = 16;
    localparam int LW     = (MAC_NUM > 1) ? $clog2(MAC_NUM) : 1;

    logic [LANE_W-1:0] lane;

    assign lane = LANE_W'(beat) * LANE_W'(VPB) + LANE_W'(K);
    // lanes past the valid channel count are zero-filled
    assign val  = (lane < LANE_W'(size)) ? vec[lane[LW-1:0]] : '0;
endmodule

module axis_ofmaps_unload #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int MAC_NUM              = 256,
    parameter int VAL_W                = 5,
    parameter int FIFO_DEPTH           = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [VAL_W*MAC_NUM-1:0]        ofmaps_in,
    input  logic                            MAC_write,
    output logic                            fifo_full,
    output logic                            fifo_empty,
    input  logic [11:0]                     output_channel_size,
    input  logic [15:0]                     frame_vector_num,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            busy,
    output logic                            frame_done
`ifdef AXIS_OFMAPS_UNLOAD_OVF_EN
    ,
    output logic                            overflow_err
`endif
);
    localparam int VPB    = C_M_AXIS_TDATA_WIDTH / VAL_W;
    localparam int NB_MAX = (MAC_NUM + VPB - 1) / VPB;
    localparam int BW     = $clog2(NB_MAX + 1);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;

    typedef logic [MAC_NUM-1:0][VAL_W-1:0] vec_t;
    typedef enum logic {IDLE, SEND} state_t;

    vec_t            mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    vec_t            head;

    state_t          st;
    vec_t            vec_q;
    logic [BW-1:0]   beat, nb_q;
    logic [11:0]     size_q;
    logic [15:0]     frm_q, vcnt;

    logic            hs, last_beat, end_vec, end_frm, pop, push, first;
    logic [15:0]     vcnt_nxt, frm_in, ld_frm;
    logic [11:0]     size_in, ld_size, src_size;
    logic [BW-1:0]   ld_nb, src_beat;
    vec_t            src_vec;
    logic            tlast_nxt;
    logic [VPB-1:0][VAL_W-1:0]       slot_val;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] pack;

    assign head       = mem[rd_ptr];
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign busy       = (st == SEND);

    always_comb begin
        hs        = m_axis_tvalid & m_axis_tready;
        last_beat = (beat == nb_q - 1'b1);
        end_vec   = hs & last_beat;
        end_frm   = end_vec & m_axis_tlast;
        // a vector-ending handshake refills from the FIFO in the same cycle
        pop       = ~fifo_empty & ((st == IDLE) | end_vec);
        push      = MAC_write & (~fifo_full | pop);
        vcnt_nxt  = end_frm ? 16'd0 : (end_vec ? vcnt + 16'd1 : vcnt);
        first     = (vcnt_nxt == 16'd0);
        size_in   = (output_channel_size == 12'd0 || output_channel_size > 12'(MAC_NUM))
                    ? 12'(MAC_NUM) : output_channel_size;
        frm_in    = (frame_vector_num == 16'd0) ? 16'd1 : frame_vector_num;
        ld_size   = first ? size_in : size_q;
        ld_frm    = first ? frm_in : frm_q;
        ld_nb     = BW'((ld_size + 12'(VPB - 1)) / 12'(VPB));
        src_vec   = pop ? head : vec_q;
        src_beat  = pop ? '0 : beat + 1'b1;
        src_size  = pop ? ld_size : size_q;
        tlast_nxt = pop ? ((ld_nb == BW'(1)) && (vcnt_nxt == ld_frm - 16'd1))
                        : ((beat + 1'b1 == nb_q - 1'b1) && (vcnt == frm_q - 16'd1));
        pack      = C_M_AXIS_TDATA_WIDTH'(slot_val);
    end

    for (genvar k = 0; k < VPB; k++) begin : g_slot
        axis_ofmaps_unload_slot #(
            .MAC_NUM(MAC_NUM), .VAL_W(VAL_W), .VPB(VPB), .K(k), .BW(BW)
        ) u_slot (
            .vec (src_vec),
            .beat(src_beat),
            .size(src_size),
            .val (slot_val[k])
        );
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ofmaps_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st            <= IDLE;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            beat          <= '0;
            nb_q          <= BW'(1);
            size_q        <= '0;
            frm_q         <= 16'd1;
            vcnt          <= '0;
            vec_q         <= '0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= end_frm;
            vcnt       <= vcnt_nxt;
            if (pop) begin
                st            <= SEND;
                m_axis_tvalid <= 1'b1;
                vec_q         <= head;
                beat          <= '0;
                size_q        <= ld_size;
                frm_q         <= ld_frm;
                nb_q          <= ld_nb;
                m_axis_tdata  <= pack;
                m_axis_tlast  <= tlast_nxt;
            end else if (end_vec) begin
                st            <= IDLE;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                m_axis_tdata  <= '0;
            end else if (hs) begin
                beat          <= beat + 1'b1;
                m_axis_tdata  <= pack;
                m_axis_tlast  <= tlast_nxt;
            end
        end
    end

`ifdef AXIS_OFMAPS_UNLOAD_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              overflow_err <= 1'b0;
        else if (MAC_write & fifo_full & ~pop) overflow_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_axis_ofmaps_unload.sv
// Scoreboard bench for axis_ofmaps_unload: expected beats queued at push, compared at handshake.
module tb_axis_ofmaps_unload;
    localparam int TW    = 32;
    localparam int MACN  = 256;
    localparam int VW    = 5;
    localparam int DEPTH = 4;
    localparam int VPB   = TW / VW;
    localparam int VECW  = VW * MACN;

    logic            clk = 1'b0;
    logic            rst;
    logic [VECW-1:0] ofmaps_in;
    logic            MAC_write;
    logic            fifo_full, fifo_empty;
    logic [11:0]     output_channel_size;
    logic [15:0]     frame_vector_num;
    logic [TW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic            busy, frame_done;
`ifdef AXIS_OFMAPS_UNLOAD_OVF_EN
    logic            overflow_err;
`endif

    axis_ofmaps_unload #(
        .C_M_AXIS_TDATA_WIDTH(TW), .MAC_NUM(MACN), .VAL_W(VW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .ofmaps_in(ofmaps_in), .MAC_write(MAC_write),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .output_channel_size(output_channel_size), .frame_vector_num(frame_vector_num),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .frame_done(frame_done)
`ifdef AXIS_OFMAPS_UNLOAD_OVF_EN
        , .overflow_err(overflow_err)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          beats_seen = 0;
    logic [32:0] exp_q[$];
    int          tb_vidx = 0;
    int          tb_sz = 256;
    int          tb_fr = 1;

    function automatic logic [VECW-1:0] mod32_vec();
        logic [VECW-1:0] v;
        for (int j = 0; j < MACN; j++) v[j*VW +: VW] = 5'(j % 32);
        return v;
    endfunction

    function automatic logic [VECW-1:0] rand_vec();
        logic [VECW-1:0] v;
        for (int j = 0; j < MACN; j++) v[j*VW +: VW] = 5'($urandom_range(1, 31));
        return v;
    endfunction

    // reference model: beats for one accepted vector under the current size/frame inputs
    task automatic model_push(input logic [VECW-1:0] v);
        int nb, lane;
        logic [31:0] d;
        logic l;
        if (tb_vidx == 0) begin
            tb_sz = (output_channel_size == 0 || output_channel_size > MACN) ? MACN : int'(output_channel_size);
            tb_fr = (frame_vector_num == 0) ? 1 : int'(frame_vector_num);
        end
        nb = (tb_sz + VPB - 1) / VPB;
        for (int b = 0; b < nb; b++) begin
            d = '0;
            for (int k = 0; k < VPB; k++) begin
                lane = b * VPB + k;
                if (lane < tb_sz) d[k*VW +: VW] = v[lane*VW +: VW];
            end
            l = (b == nb - 1) && (tb_vidx == tb_fr - 1);
            exp_q.push_back({l, d});
        end
        tb_vidx = (tb_vidx == tb_fr - 1) ? 0 : tb_vidx + 1;
    endtask

    task automatic push(input logic [VECW-1:0] v);
        ofmaps_in = v;
        MAC_write = 1'b1;
        @(posedge clk); #1;
        MAC_write = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats still expected after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // monitor: scoreboard compare, hold-stability under backpressure, frame_done timing
    initial begin
        logic        hold_pend, fd_due, hold_l;
        logic [31:0] hold_d;
        logic [32:0] e;
        hold_pend = 1'b0; fd_due = 1'b0; hold_l = 1'b0; hold_d = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 1'b0;
                fd_due    = 1'b0;
            end else begin
                if (fd_due || frame_done) begin
                    checks++;
                    if (frame_done !== fd_due) begin
                        errors++;
                        $display("FAIL frame_done: got %b expected %b", frame_done, fd_due);
                    end
                end
                fd_due = 1'b0;
                if (hold_pend) begin
                    checks++;
                    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold_d || m_axis_tlast !== hold_l) begin
                        errors++;
                        $display("FAIL hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                                 m_axis_tvalid, m_axis_tdata, m_axis_tlast, hold_d, hold_l);
                    end
                end
                hold_pend = m_axis_tvalid && !m_axis_tready;
                hold_d    = m_axis_tdata;
                hold_l    = m_axis_tlast;
                if (m_axis_tvalid && m_axis_tready) begin
                    beats_seen++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat: unexpected beat d=%h l=%b, none expected", m_axis_tdata, m_axis_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_axis_tlast, m_axis_tdata} !== e) begin
                            errors++;
                            $display("FAIL beat: got d=%h l=%b expected d=%h l=%b",
                                     m_axis_tdata, m_axis_tlast, e[31:0], e[32]);
                        end
                        fd_due = e[32];
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, busy, frame_done, fifo_empty, fifo_full} !== 6'b000010
            || m_axis_tdata !== 32'h0) begin
            errors++;
            $display("FAIL reset: got v=%b l=%b busy=%b fd=%b e=%b f=%b d=%h expected 0 0 0 0 1 0 0",
                     m_axis_tvalid, m_axis_tlast, busy, frame_done, fifo_empty, fifo_full, m_axis_tdata);
        end
`ifdef AXIS_OFMAPS_UNLOAD_OVF_EN
        checks++;
        if (overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b expected 0", overflow_err);
        end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [VECW-1:0] v;
        int b0;
        output_channel_size = 12'd256; frame_vector_num = 16'd1; m_axis_tready = 1'b1;
        v = mod32_vec();
        b0 = beats_seen;
        model_push(v);
        push(v);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL latency_write: tvalid got %b expected 0", m_axis_tvalid);
        end
        @(posedge clk); #1;
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0A418820) begin
            errors++;
            $display("FAIL first_beat: got v=%b d=%h expected v=1 d=0a418820", m_axis_tvalid, m_axis_tdata);
        end
        wait_drain(200);
        checks++;
        if (beats_seen - b0 != 43 || busy !== 1'b0 || fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL single: got beats=%0d busy=%b empty=%b expected 43 0 1", beats_seen - b0, busy, fifo_empty);
        end
    endtask

    task automatic test_back_to_back();
        logic [VECW-1:0] v;
        int cnt, first_c, last_c;
        output_channel_size = 12'd10; frame_vector_num = 16'd3; m_axis_tready = 1'b1;
        cnt = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 20; c++) begin
            if (c < 3) begin
                v = rand_vec();
                model_push(v);
                ofmaps_in = v;
                MAC_write = 1'b1;
            end else begin
                MAC_write = 1'b0;
            end
            @(negedge clk);
            if (m_axis_tvalid) begin
                cnt++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            @(posedge clk); #1;
        end
        MAC_write = 1'b0;
        checks++;
        if (cnt != 6 || last_c - first_c != 5) begin
            errors++;
            $display("FAIL back_to_back: got %0d valid cycles over span %0d expected 6 over 5", cnt, last_c - first_c);
        end
        wait_drain(20);
    endtask

    task automatic test_backpressure();
        logic [VECW-1:0] v;
        int b0;
        output_channel_size = 12'd12; frame_vector_num = 16'd1; m_axis_tready = 1'b0;
        v = rand_vec();
        b0 = beats_seen;
        model_push(v);
        push(v);
        for (int i = 0; i < 40; i++) begin
            m_axis_tready = ~m_axis_tready;
            @(posedge clk); #1;
            if (exp_q.size() == 0) break;
        end
        m_axis_tready = 1'b1;
        wait_drain(10);
        checks++;
        if (beats_seen - b0 != 2) begin
            errors++;
            $display("FAIL backpressure: got %0d beats expected 2", beats_seen - b0);
        end
    endtask

    task automatic test_full();
        logic [VECW-1:0] v;
        output_channel_size = 12'd6; frame_vector_num = 16'd1; m_axis_tready = 1'b0;
        // first vector parks in the unload register, the next four fill the FIFO
        for (int i = 0; i < 4; i++) begin
            v = rand_vec();
            model_push(v);
            push(v);
        end
        checks++;
        if (fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL full_3: got fifo_full=%b expected 0", fifo_full);
        end
        v = rand_vec();
        model_push(v);
        push(v);
        checks++;
        if (fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL full_4: got fifo_full=%b expected 1", fifo_full);
        end
        push(rand_vec());
        checks++;
        if (fifo_full !== 1'b1 || fifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL drop: got full=%b empty=%b expected 1 0", fifo_full, fifo_empty);
        end
`ifdef AXIS_OFMAPS_UNLOAD_OVF_EN
        checks++;
        if (overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf: got %b expected 1", overflow_err);
        end
`endif
        // push while full with a same-cycle pop is accepted
        v = rand_vec();
        model_push(v);
        m_axis_tready = 1'b1;
        push(v);
        checks++;
        if (fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL push_pop_full: got fifo_full=%b expected 1", fifo_full);
        end
        wait_drain(50);
        checks++;
        if (fifo_empty !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: got empty=%b busy=%b expected 1 0", fifo_empty, busy);
        end
    endtask

    task automatic test_zero_size();
        logic [VECW-1:0] v;
        int b0;
        output_channel_size = 12'd0; frame_vector_num = 16'd0; m_axis_tready = 1'b1;
        v = rand_vec();
        b0 = beats_seen;
        model_push(v);
        push(v);
        wait_drain(200);
        checks++;
        if (beats_seen - b0 != 43) begin
            errors++;
            $display("FAIL zero_size: got %0d beats expected 43", beats_seen - b0);
        end
    endtask

    task automatic test_reset_mid();
        logic [VECW-1:0] v;
        int b0;
        output_channel_size = 12'd256; frame_vector_num = 16'd1; m_axis_tready = 1'b1;
        b0 = beats_seen;
        v = rand_vec(); model_push(v); push(v);
        v = rand_vec(); model_push(v); push(v);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (beats_seen - b0 >= 10) break;
        end
        #1;
        checks++;
        if (beats_seen - b0 != 10) begin
            errors++;
            $display("FAIL mid_wait: got %0d beats expected 10", beats_seen - b0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || fifo_empty !== 1'b1 || busy !== 1'b0 || m_axis_tdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b empty=%b busy=%b d=%h expected 0 1 0 0",
                     m_axis_tvalid, fifo_empty, busy, m_axis_tdata);
        end
        exp_q.delete();
        tb_vidx = 0;
        rst = 1'b0;
        @(posedge clk); #1;
        b0 = beats_seen;
        v = rand_vec(); model_push(v); push(v);
        wait_drain(200);
        checks++;
        if (beats_seen - b0 != 43) begin
            errors++;
            $display("FAIL restart: got %0d beats expected 43", beats_seen - b0);
        end
    endtask

    initial begin
        rst = 1'b1; MAC_write = 1'b0; ofmaps_in = '0; m_axis_tready = 1'b0;
        output_channel_size = 12'd256; frame_vector_num = 16'd1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_full();
        test_zero_size();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
